// File: rtl/led_ctrl_mmio.sv
// Memory-mapped LED controller: atomic SET/CLR/TOG updates, per-bit blink,
// global PWM dimming and registered readback on the CPU data bus.
module led_ctrl_mmio #(
  parameter int LED_W   = 24,
  parameter int ADDR_W  = 14,
  parameter int BLINK_W = 24,
  parameter int PWM_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [31:0]       rdata,
  output logic              rd_valid,
  output logic [LED_W-1:0]  led
);

  typedef enum logic [2:0] {
    A_DATA  = 3'd0,
    A_SET   = 3'd1,
    A_CLR   = 3'd2,
    A_TOG   = 3'd3,
    A_BMASK = 3'd4,
    A_BPER  = 3'd5,
    A_DUTY  = 3'd6,
    A_STAT  = 3'd7
  } reg_idx_t;

  reg_idx_t           idx;
  logic [LED_W-1:0]   wd_led;
  logic [BLINK_W-1:0] wd_blink;
  logic [PWM_W-1:0]   wd_pwm;

  logic [LED_W-1:0]   data;
  logic [LED_W-1:0]   bmask;
  logic [BLINK_W-1:0] bper;
  logic [PWM_W-1:0]   duty;
  logic [BLINK_W-1:0] blink_cnt;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               phase;
  logic               pwm_on;
  logic               bper_wr;
  logic [31:0]        rd_mux;

  // Upper address bits and unused wdata bits are decoded elsewhere or ignored.
  logic unused_bits;
  assign unused_bits = ^{addr[ADDR_W-1:3], wdata};

  assign idx      = reg_idx_t'(addr[2:0]);
  assign wd_led   = wdata[LED_W-1:0];
  assign wd_blink = wdata[BLINK_W-1:0];
  assign wd_pwm   = wdata[PWM_W-1:0];
  assign bper_wr  = wr_en && (idx == A_BPER);
  assign pwm_on   = (duty == '1) || (pwm_cnt < duty);

  // NOTE: state registers use non-blocking assignments so every block samples
  // pre-edge values; blocking here would leak new values into sibling blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      bmask <= '0;
      bper  <= '0;
      duty  <= '1;
    end else if (wr_en) begin
      case (idx)
        A_DATA:  data  <= wd_led;
        A_SET:   data  <= data | wd_led;
        A_CLR:   data  <= data & ~wd_led;
        A_TOG:   data  <= data ^ wd_led;
        A_BMASK: bmask <= wd_led;
        A_BPER:  bper  <= wd_blink;
        A_DUTY:  duty  <= wd_pwm;
        default: ;
      endcase
    end
  end

  // Blink phase restarts high whenever the half-period is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (bper_wr || (bper == '0)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == bper - BLINK_W'(1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led     <= pwm_on ? (data & ~(bmask & {LED_W{~phase}})) : '0;
    end
  end

  // NOTE: every signal driven in always_comb gets a default first; a missed
  // case arm would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (idx)
      A_DATA:  rd_mux = 32'(data);
      A_BMASK: rd_mux = 32'(bmask);
      A_BPER:  rd_mux = 32'(bper);
      A_DUTY:  rd_mux = 32'(duty);
      A_STAT:  rd_mux = {30'b0, pwm_on, phase};
      default: rd_mux = '0;
    endcase
  end

  // Reads sample pre-edge registers, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_led_ctrl_mmio.sv
// Self-checking bench for led_ctrl_mmio: cycle-time behavioural model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_led_ctrl_mmio;

  logic        clk;
  logic        rst_n;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;
  logic        rd_valid;
  logic [23:0] led;

  int checks = 0;
  int errors = 0;

  led_ctrl_mmio dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .led      (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase and PWM position derived from elapsed cycles, not counters.
  int unsigned m_edges, epoch;
  logic [23:0] m_data, m_bmask, m_bper;
  logic [7:0]  m_duty;
  logic [23:0] exp_led;
  logic [31:0] exp_rdata;
  logic        exp_rv;

  function automatic logic m_phase();
    if (m_bper == 0) return 1'b1;
    return (((m_edges - epoch) / int'(m_bper)) % 2) == 0;
  endfunction

  function automatic logic m_pwm_on();
    return (m_duty == 8'hFF) || ((m_edges % 256) < int'(m_duty));
  endfunction

  function automatic logic [23:0] m_led();
    if (!m_pwm_on()) return 24'h0;
    return m_phase() ? m_data : (m_data & ~m_bmask);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {8'h0, m_data};
      3'd4:    return {8'h0, m_bmask};
      3'd5:    return {8'h0, m_bper};
      3'd6:    return {24'h0, m_duty};
      3'd7:    return {30'h0, m_pwm_on(), m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0; epoch = 0;
      m_data = 0; m_bmask = 0; m_bper = 0; m_duty = 8'hFF;
      exp_led = 0; exp_rdata = 0; exp_rv = 0;
    end else begin
      exp_led = m_led();
      exp_rv  = rd_en;
      if (rd_en) exp_rdata = m_read(addr[2:0]);
      m_edges++;
      if (wr_en) begin
        case (addr[2:0])
          3'd0: m_data  = wdata[23:0];
          3'd1: m_data  = m_data | wdata[23:0];
          3'd2: m_data  = m_data & ~wdata[23:0];
          3'd3: m_data  = m_data ^ wdata[23:0];
          3'd4: m_bmask = wdata[23:0];
          3'd5: begin m_bper = wdata[23:0]; epoch = m_edges; end
          3'd6: m_duty  = wdata[7:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("model_led", {8'h0, led}, {8'h0, exp_led});
    check("model_rd_valid", {31'h0, rd_valid}, {31'h0, exp_rv});
    check("model_rdata", rdata, exp_rdata);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = {11'h5A5, a}; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = {11'h2C3, a}; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int nz;
    rst_n = 1'b0; addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", {8'h0, led}, 32'h0);
    check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    rst_n = 1'b1;

    rd(3'd6, v);
    check("reset_duty", v, 32'h0000_00FF);
    rd(3'd7, v);
    check("reset_stat", v, 32'h0000_0003);

    wr(3'd0, 32'h0000_F0F0 | 32'hFF00_0000);
    wr(3'd1, 32'h0000_000F);
    wr(3'd2, 32'h0000_00F0);
    wr(3'd3, 32'h0080_0001);
    @(negedge clk);
    check("atomic_led", {8'h0, led}, 32'h0080_F00E);
    rd(3'd0, v);
    check("atomic_data", v, 32'h0080_F00E);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd1, v);
    check("read_set_zero", v, 32'h0);

    wr(3'd0, 32'h0000_0003);
    wr(3'd4, 32'h0000_0001);
    wr(3'd5, 32'h0000_0004);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("blink_seq", {8'h0, led}, ((((k - 1) / 4) % 2) == 1) ? 32'h2 : 32'h3);
    end
    repeat (2) @(negedge clk);
    check("blink_phase0", {8'h0, led}, 32'h2);
    wr(3'd5, 32'h0000_0004);
    @(negedge clk);
    check("blink_restart", {8'h0, led}, 32'h3);
    rd(3'd5, v);
    check("bper_read", v, 32'h4);

    wr(3'd4, 32'h0);
    wr(3'd0, 32'h00FF_FFFF);
    wr(3'd6, 32'h0000_0040);
    @(negedge clk);
    nz = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led != 0) nz++;
    end
    check("pwm_on_count", nz, 64);
    wr(3'd6, 32'h0);
    @(negedge clk);
    nz = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led != 0) nz++;
    end
    check("pwm_zero_count", nz, 0);

    wr(3'd6, 32'hFF);
    wr(3'd0, 32'h0000_0011);
    @(negedge clk);
    addr = 14'h0; wdata = 32'h0000_0022; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw_same_old", rdata, 32'h0000_0011);
    check("rw_same_valid", {31'h0, rd_valid}, 32'h1);
    @(negedge clk);
    check("rdata_hold", rdata, 32'h0000_0011);
    check("rd_valid_drop", {31'h0, rd_valid}, 32'h0);
    rd(3'd0, v);
    check("rw_same_new", v, 32'h0000_0022);

    wr(3'd0, 32'h0000_0003);
    wr(3'd4, 32'h0000_0001);
    wr(3'd5, 32'h0000_0003);
    wr(3'd6, 32'h0000_0080);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", {8'h0, led}, 32'h0);
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd7, v);
    check("post_rst_stat", v, 32'h3);
    rd(3'd5, v);
    check("post_rst_bper", v, 32'h0);
    rd(3'd0, v);
    check("post_rst_data", v, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
